// File: rtl/axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// axi_lite_regbank
//
// Parametrised AXI4-Lite slave register bank for the SNN core. It provides:
// a constant VERSION word, a write-one-to-clear interrupt status block with
// an enable mask, NUM_RW read/write control registers and NUM_RO read-only
// status inputs. Unmapped or reserved words answer with SLVERR.
//
// Ports
//   i_s_axi_aclk / i_s_axi_areset   clock, synchronous active-high reset
//   i_s_axi_aw* / w* / b*           write address, data and response channels
//   i_s_axi_ar* / r*                read address and data channels
//   o_rw_regs      NUM_RW*32  read/write register contents, reg i at [32*i +: 32]
//   o_rw_wr_pulse  NUM_RW     one-cycle pulse in the cycle after reg i is written
//   i_ro_regs      NUM_RO*32  read-only inputs, sampled on the AR handshake
//   i_irq_src      NUM_IRQ    level sources, set IRQ_STATUS every cycle they are high
//   o_irq          1          registered OR of (IRQ_STATUS & IRQ_ENABLE)
//
// Word map (addr[1:0] ignored): 0x00 VERSION, 0x04 IRQ_STATUS (W1C),
// 0x08 IRQ_ENABLE, 0x0C reserved, 0x10+4i RW reg i, then RO reg j.
// ---------------------------------------------------------------------------
module axi_lite_regbank #(
    parameter int                   C_S_AXI_ADDR_WIDTH = 8,
    parameter int                   NUM_RW             = 8,
    parameter int                   NUM_RO             = 4,
    parameter int                   NUM_IRQ            = 8,
    parameter logic [NUM_RW*32-1:0] RW_RESET           = '0,
    parameter logic [31:0]          VERSION            = 32'h2024_0200
) (
    input  logic                          i_s_axi_aclk,
    input  logic                          i_s_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] i_s_axi_awaddr,
    input  logic [2:0]                    i_s_axi_awprot,
    input  logic                          i_s_axi_awvalid,
    output logic                          o_s_axi_awready,
    input  logic [31:0]                   i_s_axi_wdata,
    input  logic [3:0]                    i_s_axi_wstrb,
    input  logic                          i_s_axi_wvalid,
    output logic                          o_s_axi_wready,
    output logic [1:0]                    o_s_axi_bresp,
    output logic                          o_s_axi_bvalid,
    input  logic                          i_s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] i_s_axi_araddr,
    input  logic [2:0]                    i_s_axi_arprot,
    input  logic                          i_s_axi_arvalid,
    output logic                          o_s_axi_arready,
    output logic [31:0]                   o_s_axi_rdata,
    output logic [1:0]                    o_s_axi_rresp,
    output logic                          o_s_axi_rvalid,
    input  logic                          i_s_axi_rready,
    output logic [NUM_RW*32-1:0]          o_rw_regs,
    output logic [NUM_RW-1:0]             o_rw_wr_pulse,
    input  logic [NUM_RO*32-1:0]          i_ro_regs,
    input  logic [NUM_IRQ-1:0]            i_irq_src,
    output logic                          o_irq
);

    localparam int IW      = C_S_AXI_ADDR_WIDTH - 2;
    localparam int RW_BASE = 4;
    localparam int RO_BASE = RW_BASE + NUM_RW;
    localparam int RO_END  = RO_BASE + NUM_RO;

    logic [IW-1:0]      r_aw_word;
    logic               r_aw_held;
    logic [31:0]        r_w_data;
    logic [3:0]         r_w_strb;
    logic               r_w_held;
    logic               r_bvalid;
    logic [1:0]         r_bresp;
    logic               r_rvalid;
    logic [31:0]        r_rdata;
    logic [1:0]         r_rresp;
    logic [31:0]        r_rw [NUM_RW];
    logic [NUM_RW-1:0]  r_wr_pulse;
    logic [NUM_IRQ-1:0] r_irq_status;
    logic [NUM_IRQ-1:0] r_irq_enable;
    logic               r_irq;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_ar_hs;
    logic               w_exec;
    logic               w_wr_ok;
    logic [31:0]        w_wr_word;
    logic [31:0]        w_wr_data;
    logic [3:0]         w_wr_strb;
    logic [31:0]        w_wr_mask;
    logic [31:0]        w_w1c;
    logic [31:0]        w_rd_word;
    logic [31:0]        w_rd_data;
    logic [1:0]         w_rd_resp;
    logic               w_unused;

    // Readies are forced low while reset is asserted so no handshake can
    // complete during reset.
    assign o_s_axi_awready = !r_aw_held && !i_s_axi_areset;
    assign o_s_axi_wready  = !r_w_held && !i_s_axi_areset;
    assign o_s_axi_arready = !r_rvalid && !i_s_axi_areset;

    assign w_aw_hs = i_s_axi_awvalid && o_s_axi_awready;
    assign w_w_hs  = i_s_axi_wvalid && o_s_axi_wready;
    assign w_ar_hs = i_s_axi_arvalid && o_s_axi_arready;

    // A write executes in the same cycle the second half arrives, so the
    // effective address/data bypass the holding registers when not yet held.
    // Execution waits while a previous response is still unacknowledged.
    always_comb begin
        w_wr_word = r_aw_held ? 32'(r_aw_word) : 32'(i_s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2]);
        w_wr_data = r_w_held ? r_w_data : i_s_axi_wdata;
        w_wr_strb = r_w_held ? r_w_strb : i_s_axi_wstrb;
        w_wr_mask = {{8{w_wr_strb[3]}}, {8{w_wr_strb[2]}}, {8{w_wr_strb[1]}}, {8{w_wr_strb[0]}}};
        w_exec    = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs) && !r_bvalid;
        w_wr_ok   = (w_wr_word < 32'(RO_END)) && (w_wr_word != 32'd3);
        w_w1c     = (w_exec && w_wr_word == 32'd1) ? (w_wr_data & w_wr_mask) : 32'd0;
    end

    // Write-channel holding registers and the B response. Holds are cleared
    // when the write executes; a new AW/W may be captured while B is pending.
    always_ff @(posedge i_s_axi_aclk) begin
        if (i_s_axi_areset) begin
            r_aw_held <= 1'b0;
            r_aw_word <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
        end else begin
            if (w_aw_hs) begin
                r_aw_word <= i_s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_w_hs) begin
                r_w_data <= i_s_axi_wdata;
                r_w_strb <= i_s_axi_wstrb;
            end
            if (w_exec) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_ok ? 2'b00 : 2'b10;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                end
                if (r_bvalid && i_s_axi_bready) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    // Register file update with byte strobes. The write pulse fires for a
    // mapped RW register even when all of its strobes are zero.
    always_ff @(posedge i_s_axi_aclk) begin
        if (i_s_axi_areset) begin
            for (int i = 0; i < NUM_RW; i++) begin
                r_rw[i] <= RW_RESET[32*i +: 32];
            end
            r_wr_pulse   <= '0;
            r_irq_enable <= '0;
            r_irq_status <= '0;
            r_irq        <= 1'b0;
        end else begin
            r_wr_pulse <= '0;
            if (w_exec) begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (w_wr_word == 32'(RW_BASE + i)) begin
                        r_rw[i]       <= (r_rw[i] & ~w_wr_mask) | (w_wr_data & w_wr_mask);
                        r_wr_pulse[i] <= 1'b1;
                    end
                end
                if (w_wr_word == 32'd2) begin
                    r_irq_enable <= (r_irq_enable & ~w_wr_mask[NUM_IRQ-1:0])
                                  | (w_wr_data[NUM_IRQ-1:0] & w_wr_mask[NUM_IRQ-1:0]);
                end
            end
            r_irq_status <= (r_irq_status & ~w_w1c[NUM_IRQ-1:0]) | i_irq_src;
            r_irq        <= |(r_irq_status & r_irq_enable);
        end
    end

    // Read decode from the live AR address; registered on the handshake so
    // the read sees register values from before any same-cycle write.
    always_comb begin
        w_rd_word = 32'(i_s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]);
        w_rd_data = 32'hDEAD_BEEF;
        w_rd_resp = 2'b10;
        if (w_rd_word == 32'd0) begin
            w_rd_data = VERSION;
            w_rd_resp = 2'b00;
        end else if (w_rd_word == 32'd1) begin
            w_rd_data = 32'(r_irq_status);
            w_rd_resp = 2'b00;
        end else if (w_rd_word == 32'd2) begin
            w_rd_data = 32'(r_irq_enable);
            w_rd_resp = 2'b00;
        end
        for (int i = 0; i < NUM_RW; i++) begin
            if (w_rd_word == 32'(RW_BASE + i)) begin
                w_rd_data = r_rw[i];
                w_rd_resp = 2'b00;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (w_rd_word == 32'(RO_BASE + j)) begin
                w_rd_data = i_ro_regs[32*j +: 32];
                w_rd_resp = 2'b00;
            end
        end
    end

    // Read data channel: RVALID rises the cycle after AR and holds with
    // stable data until RREADY; ARREADY stays low meanwhile.
    always_ff @(posedge i_s_axi_aclk) begin
        if (i_s_axi_areset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && i_s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    always_comb begin
        o_rw_regs = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            o_rw_regs[32*i +: 32] = r_rw[i];
        end
    end

    assign o_rw_wr_pulse  = r_wr_pulse;
    assign o_s_axi_bvalid = r_bvalid;
    assign o_s_axi_bresp  = r_bresp;
    assign o_s_axi_rvalid = r_rvalid;
    assign o_s_axi_rdata  = r_rdata;
    assign o_s_axi_rresp  = r_rresp;
    assign o_irq          = r_irq;

    // Protection bits and byte-offset address bits carry no meaning here.
    assign w_unused = ^{i_s_axi_awprot, i_s_axi_arprot, i_s_axi_awaddr[1:0], i_s_axi_araddr[1:0]};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regbank
//
// Self-checking bench for axi_lite_regbank. A behavioural model of the
// register map (arrays of register values, interrupt status and enable)
// provides every expected response, read value and register content.
// ---------------------------------------------------------------------------
module tb_axi_lite_regbank;

    localparam int AW   = 8;
    localparam int NRW  = 8;
    localparam int NRO  = 4;
    localparam int NIRQ = 8;
    localparam logic [31:0] VERSION = 32'h2024_0200;
    localparam logic [NRW*32-1:0] RW_RESET = {
        32'hC0DE_0007, 32'hC0DE_0006, 32'hC0DE_0005, 32'hC0DE_0004,
        32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};

    logic              clock = 1'b0;
    logic              reset;
    logic [AW-1:0]     awAddr;
    logic              awValid;
    logic              awReady;
    logic [31:0]       wData;
    logic [3:0]        wStrb;
    logic              wValid;
    logic              wReady;
    logic [1:0]        bResp;
    logic              bValid;
    logic              bReady;
    logic [AW-1:0]     arAddr;
    logic              arValid;
    logic              arReady;
    logic [31:0]       rData;
    logic [1:0]        rResp;
    logic              rValid;
    logic              rReady;
    logic [2:0]        protZero;
    logic [NRW*32-1:0] rwRegs;
    logic [NRW-1:0]    rwWrPulse;
    logic [NRO*32-1:0] roRegs;
    logic [NIRQ-1:0]   irqSrc;
    logic              irq;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0]     rwModel [NRW];
    logic [NIRQ-1:0] statusModel;
    logic [NIRQ-1:0] enableModel;

    always #5 clock = ~clock;

    axi_lite_regbank #(
        .C_S_AXI_ADDR_WIDTH(AW), .NUM_RW(NRW), .NUM_RO(NRO), .NUM_IRQ(NIRQ),
        .RW_RESET(RW_RESET), .VERSION(VERSION)
    ) dut (
        .i_s_axi_aclk(clock), .i_s_axi_areset(reset),
        .i_s_axi_awaddr(awAddr), .i_s_axi_awprot(protZero), .i_s_axi_awvalid(awValid),
        .o_s_axi_awready(awReady),
        .i_s_axi_wdata(wData), .i_s_axi_wstrb(wStrb), .i_s_axi_wvalid(wValid),
        .o_s_axi_wready(wReady),
        .o_s_axi_bresp(bResp), .o_s_axi_bvalid(bValid), .i_s_axi_bready(bReady),
        .i_s_axi_araddr(arAddr), .i_s_axi_arprot(protZero), .i_s_axi_arvalid(arValid),
        .o_s_axi_arready(arReady),
        .o_s_axi_rdata(rData), .o_s_axi_rresp(rResp), .o_s_axi_rvalid(rValid),
        .i_s_axi_rready(rReady),
        .o_rw_regs(rwRegs), .o_rw_wr_pulse(rwWrPulse), .i_ro_regs(roRegs),
        .i_irq_src(irqSrc), .o_irq(irq)
    );

    // Model: restore reset contents of the register map.
    function automatic void resetModel();
        for (int i = 0; i < NRW; i++) rwModel[i] = 32'hC0DE_0000 + 32'(i);
        statusModel = '0;
        enableModel = '0;
    endfunction

    // Model: apply one write to the map and return the expected BRESP.
    function automatic logic [1:0] applyWrite(input logic [AW-1:0] a, input logic [31:0] d,
                                              input logic [3:0] s);
        logic [31:0] m;
        logic [31:0] c;
        int w;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        c = d & m;
        w = int'(a >> 2);
        if (w == 0) return 2'b00;
        if (w == 1) begin
            statusModel = statusModel & ~c[NIRQ-1:0];
            return 2'b00;
        end
        if (w == 2) begin
            enableModel = (enableModel & ~m[NIRQ-1:0]) | c[NIRQ-1:0];
            return 2'b00;
        end
        if (w >= 4 && w < 4 + NRW) begin
            rwModel[w-4] = (rwModel[w-4] & ~m) | c;
            return 2'b00;
        end
        if (w >= 4 + NRW && w < 4 + NRW + NRO) return 2'b00;
        return 2'b10;
    endfunction

    // Model: expected read data and response for an address.
    function automatic void expectRead(input logic [AW-1:0] a, output logic [31:0] d,
                                       output logic [1:0] r);
        int w;
        w = int'(a >> 2);
        r = 2'b00;
        if (w == 0) d = VERSION;
        else if (w == 1) d = 32'(statusModel);
        else if (w == 2) d = 32'(enableModel);
        else if (w >= 4 && w < 4 + NRW) d = rwModel[w-4];
        else if (w >= 4 + NRW && w < 4 + NRW + NRO) d = roRegs[32*(w-4-NRW) +: 32];
        else begin
            d = 32'hDEAD_BEEF;
            r = 2'b10;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sendAw(input logic [AW-1:0] a);
        bit done;
        done = 1'b0;
        awAddr = a;
        awValid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clock);
            done = awReady;
            tick();
        end
        awValid = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("[TB] FAIL aw_timeout: awready got 0 required 1 within 50 cycles");
        end
    endtask

    task automatic sendW(input logic [31:0] d, input logic [3:0] s);
        bit done;
        done = 1'b0;
        wData = d;
        wStrb = s;
        wValid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clock);
            done = wReady;
            tick();
        end
        wValid = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("[TB] FAIL w_timeout: wready got 0 required 1 within 50 cycles");
        end
    endtask

    task automatic sendAr(input logic [AW-1:0] a);
        bit done;
        done = 1'b0;
        arAddr = a;
        arValid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clock);
            done = arReady;
            tick();
        end
        arValid = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("[TB] FAIL ar_timeout: arready got 0 required 1 within 50 cycles");
        end
    endtask

    task automatic collectB(output logic [1:0] resp);
        bit done;
        done = 1'b0;
        resp = 2'bxx;
        bReady = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clock);
            done = bValid;
            resp = bResp;
            tick();
        end
        bReady = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("[TB] FAIL b_timeout: bvalid got 0 required 1 within 50 cycles");
        end
    endtask

    task automatic collectR(output logic [31:0] data, output logic [1:0] resp);
        bit done;
        done = 1'b0;
        data = 'x;
        resp = 2'bxx;
        rReady = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clock);
            done = rValid;
            data = rData;
            resp = rResp;
            tick();
        end
        rReady = 1'b0;
        if (!done) begin
            vectors++; miscompares++;
            $display("[TB] FAIL r_timeout: rvalid got 0 required 1 within 50 cycles");
        end
    endtask

    task automatic doWrite(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
        fork
            sendAw(a);
            sendW(d, s);
        join
        collectB(resp);
    endtask

    task automatic readReg(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
        sendAr(a);
        collectR(d, r);
    endtask

    // Reset values of the outputs, then VERSION and RW reg 0 reads.
    task automatic test_reset();
        logic [31:0] d;
        logic [1:0] r;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({awReady, wReady, arReady, bValid, rValid, irq} !== 6'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_handshake: got %b required 000000",
                     {awReady, wReady, arReady, bValid, rValid, irq});
        end
        vectors++;
        if (rData !== 32'd0 || bResp !== 2'b00 || rResp !== 2'b00 || rwWrPulse !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: rdata %h bresp %b rresp %b pulse %b required zeros",
                     rData, bResp, rResp, rwWrPulse);
        end
        tick();
        reset = 1'b0;
        resetModel();
        for (int i = 0; i < NRW; i++) begin
            vectors++;
            if (rwRegs[32*i +: 32] !== rwModel[i]) begin
                miscompares++;
                $display("[TB] FAIL reset_rw%0d: got %h required %h", i, rwRegs[32*i +: 32], rwModel[i]);
            end
        end
        readReg(8'h00, d, r);
        vectors++;
        if (d !== 32'h2024_0200 || r !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_version: got %h/%b required 20240200/00", d, r);
        end
        readReg(8'h10, d, r);
        vectors++;
        if (d !== 32'hC0DE_0000 || r !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL reset_reg0: got %h/%b required c0de0000/00", d, r);
        end
    endtask

    // AW and W separated by several cycles in both orders.
    task automatic test_split_write();
        logic [1:0] r;
        sendAw(8'h14);
        repeat (4) begin
            @(negedge clock);
            vectors++;
            if (bValid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL split_early_b: bvalid got %b required 0", bValid);
            end
            tick();
        end
        sendW(32'hA5A5_1234, 4'b0011);
        vectors++;
        if (bValid !== 1'b1 || rwWrPulse !== 8'b0000_0010 || rwRegs[63:32] !== 32'hC0DE_1234) begin
            miscompares++;
            $display("[TB] FAIL split_write: bvalid %b pulse %b reg1 %h required 1 00000010 c0de1234",
                     bValid, rwWrPulse, rwRegs[63:32]);
        end
        r = applyWrite(8'h14, 32'hA5A5_1234, 4'b0011);
        tick();
        vectors++;
        if (rwWrPulse !== 8'b0) begin
            miscompares++;
            $display("[TB] FAIL split_pulse_len: pulse got %b required 00000000", rwWrPulse);
        end
        collectB(r);
        vectors++;
        if (r !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL split_bresp: got %b required 00", r);
        end
        sendW(32'hFFFF_0000, 4'b1100);
        repeat (3) tick();
        vectors++;
        if (bValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL wfirst_early_b: bvalid got %b required 0", bValid);
        end
        sendAw(8'h18);
        vectors++;
        if (bValid !== 1'b1 || rwRegs[95:64] !== 32'hFFFF_0002) begin
            miscompares++;
            $display("[TB] FAIL wfirst_write: bvalid %b reg2 %h required 1 ffff0002", bValid, rwRegs[95:64]);
        end
        r = applyWrite(8'h18, 32'hFFFF_0000, 4'b1100);
        collectB(r);
    endtask

    // Unmapped, reserved, VERSION and RO writes/reads.
    task automatic test_unmapped();
        logic [AW-1:0] addrs [4];
        logic [31:0] d, ed;
        logic [1:0] r, er;
        addrs = '{8'hFC, 8'h0C, 8'h00, 8'h30};
        roRegs = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        foreach (addrs[k]) begin
            doWrite(addrs[k], 32'hFFFF_FFFF, 4'hF, r);
            er = applyWrite(addrs[k], 32'hFFFF_FFFF, 4'hF);
            vectors++;
            if (r !== er) begin
                miscompares++;
                $display("[TB] FAIL unmapped_bresp @%h: got %b required %b", addrs[k], r, er);
            end
            for (int i = 0; i < NRW; i++) begin
                vectors++;
                if (rwRegs[32*i +: 32] !== rwModel[i]) begin
                    miscompares++;
                    $display("[TB] FAIL unmapped_side_effect reg%0d: got %h required %h",
                             i, rwRegs[32*i +: 32], rwModel[i]);
                end
            end
            readReg(addrs[k], d, r);
            expectRead(addrs[k], ed, er);
            vectors++;
            if (d !== ed || r !== er) begin
                miscompares++;
                $display("[TB] FAIL unmapped_read @%h: got %h/%b required %h/%b", addrs[k], d, r, ed, er);
            end
        end
    endtask

    // Random writes and reads across the map with random channel ordering.
    task automatic test_random_rw();
        logic [AW-1:0] a;
        logic [31:0] d, ed;
        logic [3:0] s;
        logic [1:0] r, er;
        logic [NRW-1:0] ep;
        int word, order, gap;
        for (int it = 0; it < 60; it++) begin
            for (int j = 0; j < NRO; j++) roRegs[32*j +: 32] = $urandom;
            word = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
            a = AW'((word << 2) | int'($urandom_range(0, 3)));
            d = $urandom;
            s = 4'($urandom);
            order = $urandom_range(0, 2);
            gap = $urandom_range(0, 3);
            ep = '0;
            if (word >= 4 && word < 4 + NRW) ep[word-4] = 1'b1;
            if (order == 0) begin
                sendAw(a);
                repeat (gap) tick();
                sendW(d, s);
            end else if (order == 1) begin
                sendW(d, s);
                repeat (gap) tick();
                sendAw(a);
            end else begin
                fork
                    sendAw(a);
                    sendW(d, s);
                join
            end
            vectors++;
            if (bValid !== 1'b1 || rwWrPulse !== ep) begin
                miscompares++;
                $display("[TB] FAIL rand_exec @%h: bvalid %b pulse %b required 1 %b", a, bValid, rwWrPulse, ep);
            end
            er = applyWrite(a, d, s);
            collectB(r);
            vectors++;
            if (r !== er) begin
                miscompares++;
                $display("[TB] FAIL rand_bresp @%h: got %b required %b", a, r, er);
            end
            for (int i = 0; i < NRW; i++) begin
                vectors++;
                if (rwRegs[32*i +: 32] !== rwModel[i]) begin
                    miscompares++;
                    $display("[TB] FAIL rand_rw%0d: got %h required %h", i, rwRegs[32*i +: 32], rwModel[i]);
                end
            end
            word = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 15));
            a = AW'((word << 2) | int'($urandom_range(0, 3)));
            sendAr(a);
            vectors++;
            if (rValid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rand_rlatency @%h: rvalid got %b required 1", a, rValid);
            end
            collectR(d, r);
            expectRead(a, ed, er);
            vectors++;
            if (d !== ed || r !== er) begin
                miscompares++;
                $display("[TB] FAIL rand_read @%h: got %h/%b required %h/%b", a, d, r, ed, er);
            end
            vectors++;
            if (irq !== |(statusModel & enableModel)) begin
                miscompares++;
                $display("[TB] FAIL rand_irq: got %b required %b", irq, |(statusModel & enableModel));
            end
        end
    endtask

    // Interrupt set, enable, W1C, set-wins-over-clear and strobed W1C.
    task automatic test_irq();
        logic [31:0] d, ed;
        logic [1:0] r, er;
        logic [AW-1:0] wa [5];
        logic [31:0]   wd [5];
        logic [3:0]    ws [5];
        logic [NIRQ-1:0] src [5];
        logic [NIRQ-1:0] pulseSrc [5];
        wa = '{8'h08, 8'h04, 8'h04, 8'h04, 8'h04};
        wd = '{32'h08, 32'h08, 32'h08, 32'h08, 32'h10};
        ws = '{4'hF, 4'hF, 4'hF, 4'hF, 4'b0001};
        src = '{8'h00, 8'h00, 8'h08, 8'h00, 8'h00};
        pulseSrc = '{8'h08, 8'h00, 8'h00, 8'h30, 8'h00};
        for (int k = 0; k < 5; k++) begin
            if (pulseSrc[k] != '0) begin
                irqSrc = pulseSrc[k];
                tick();
                statusModel = statusModel | pulseSrc[k];
            end
            irqSrc = src[k];
            if (src[k] != '0) begin
                tick();
                statusModel = statusModel | src[k];
            end
            doWrite(wa[k], wd[k], ws[k], r);
            er = applyWrite(wa[k], wd[k], ws[k]);
            statusModel = statusModel | src[k];
            vectors++;
            if (r !== er) begin
                miscompares++;
                $display("[TB] FAIL irq_bresp step%0d: got %b required %b", k, r, er);
            end
            repeat (2) tick();
            vectors++;
            if (irq !== |(statusModel & enableModel)) begin
                miscompares++;
                $display("[TB] FAIL irq_out step%0d: got %b required %b", k, irq, |(statusModel & enableModel));
            end
            readReg(8'h04, d, r);
            expectRead(8'h04, ed, er);
            vectors++;
            if (d !== ed || r !== er) begin
                miscompares++;
                $display("[TB] FAIL irq_status step%0d: got %h/%b required %h/%b", k, d, r, ed, er);
            end
        end
        irqSrc = '0;
        doWrite(8'h04, 32'hFF, 4'hF, r);
        er = applyWrite(8'h04, 32'hFF, 4'hF);
    endtask

    // BREADY/RREADY held low: stable responses, second write deferred.
    task automatic test_backpressure();
        logic [31:0] d;
        logic [1:0] r, er;
        sendAw(8'h10);
        sendW(32'h1111_2222, 4'hF);
        er = applyWrite(8'h10, 32'h1111_2222, 4'hF);
        sendAw(8'h18);
        sendW(32'h3333_4444, 4'hF);
        vectors++;
        if (awReady !== 1'b0 || wReady !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL bp_holds: awready %b wready %b required 0 0", awReady, wReady);
        end
        repeat (10) begin
            @(negedge clock);
            vectors++;
            if (bValid !== 1'b1 || bResp !== 2'b00 || rwRegs[95:64] !== rwModel[2] || rwWrPulse !== '0) begin
                miscompares++;
                $display("[TB] FAIL bp_stable: bvalid %b bresp %b reg2 %h pulse %b required 1 00 %h 0",
                         bValid, bResp, rwRegs[95:64], rwWrPulse, rwModel[2]);
            end
            tick();
        end
        collectB(r);
        collectB(r);
        er = applyWrite(8'h18, 32'h3333_4444, 4'hF);
        vectors++;
        if (r !== er || rwRegs[95:64] !== rwModel[2]) begin
            miscompares++;
            $display("[TB] FAIL bp_second: bresp %b reg2 %h required %b %h", r, rwRegs[95:64], er, rwModel[2]);
        end
        sendAr(8'h10);
        repeat (10) begin
            @(negedge clock);
            vectors++;
            if (rValid !== 1'b1 || rData !== rwModel[0] || rResp !== 2'b00 || arReady !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_rstable: rvalid %b rdata %h rresp %b arready %b required 1 %h 00 0",
                         rValid, rData, rResp, arReady, rwModel[0]);
            end
            tick();
        end
        collectR(d, r);
        vectors++;
        if (d !== rwModel[0]) begin
            miscompares++;
            $display("[TB] FAIL bp_rdata: got %h required %h", d, rwModel[0]);
        end
    endtask

    // Read and write of the same register in the same cycle.
    task automatic test_same_cycle();
        logic [31:0] d, old, ed;
        logic [1:0] r, er;
        old = rwModel[4];
        sendAw(8'h20);
        wData = 32'h600D_F00D;
        wStrb = 4'hF;
        wValid = 1'b1;
        arAddr = 8'h20;
        arValid = 1'b1;
        @(negedge clock);
        vectors++;
        if (wReady !== 1'b1 || arReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL same_ready: wready %b arready %b required 1 1", wReady, arReady);
        end
        tick();
        wValid = 1'b0;
        arValid = 1'b0;
        collectR(d, r);
        vectors++;
        if (d !== old) begin
            miscompares++;
            $display("[TB] FAIL same_preread: got %h required %h", d, old);
        end
        collectB(r);
        er = applyWrite(8'h20, 32'h600D_F00D, 4'hF);
        readReg(8'h20, d, r);
        expectRead(8'h20, ed, er);
        vectors++;
        if (d !== ed || r !== er) begin
            miscompares++;
            $display("[TB] FAIL same_postread: got %h/%b required %h/%b", d, r, ed, er);
        end
    endtask

    // Reset while AW is held: the later W alone must not write.
    task automatic test_reset_mid();
        logic [1:0] r, er;
        sendAw(8'h18);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        resetModel();
        sendW(32'h5A5A_5A5A, 4'hF);
        repeat (5) begin
            @(negedge clock);
            vectors++;
            if (bValid !== 1'b0 || rwRegs[95:64] !== rwModel[2] || awReady !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rstmid_nowrite: bvalid %b reg2 %h awready %b required 0 %h 1",
                         bValid, rwRegs[95:64], awReady, rwModel[2]);
            end
            tick();
        end
        sendAw(8'h1C);
        collectB(r);
        er = applyWrite(8'h1C, 32'h5A5A_5A5A, 4'hF);
        vectors++;
        if (r !== er || rwRegs[127:96] !== rwModel[3] || rwRegs[95:64] !== rwModel[2]) begin
            miscompares++;
            $display("[TB] FAIL rstmid_pair: bresp %b reg3 %h reg2 %h required %b %h %h",
                     r, rwRegs[127:96], rwRegs[95:64], er, rwModel[3], rwModel[2]);
        end
    endtask

    initial begin
        reset = 1'b1;
        awAddr = '0; awValid = 1'b0;
        wData = '0; wStrb = '0; wValid = 1'b0; bReady = 1'b0;
        arAddr = '0; arValid = 1'b0; rReady = 1'b0;
        protZero = 3'b000;
        roRegs = '0;
        irqSrc = '0;
        resetModel();
        test_reset();
        test_split_write();
        test_unmapped();
        test_random_rw();
        test_irq();
        test_backpressure();
        test_same_cycle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
